// File: rtl/wb_buffer_pkg.sv
// Shared types for the L2 write-back buffer.
// State encoding, entry layout and the line offset.
package wb_buffer_pkg;

   localparam int LINE_OFFSET = 5;
   localparam int MAX_TAG_W   = 27;
   localparam int MAX_LINE_W  = 256;

   typedef enum logic [1:0] {
      IDLE,
      MEM_READ,
      DRAIN,
      RESP
   } wb_state_e;

   typedef struct packed {
      logic                  valid;
      logic [MAX_TAG_W-1:0]  tag;
      logic [MAX_LINE_W-1:0] line;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular victim-line store with tag lookup.
// Push at tail, pop at head, overwrite on a tag hit.
module wb_fifo
   import wb_buffer_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int LINE_W = 256,
   parameter  int TAG_W  = 27,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [TAG_W-1:0]  lookup_tag,
   output logic              hit,
   output logic [PTR_W-1:0]  hit_idx,
   output logic [LINE_W-1:0] hit_line,
   input  logic              push,
   input  logic              ovw,
   input  logic              pop,
   input  logic [TAG_W-1:0]  push_tag,
   input  logic [LINE_W-1:0] wr_line,
   output logic [TAG_W-1:0]  head_tag,
   output logic [LINE_W-1:0] head_line,
   output logic              full,
   output logic [PTR_W:0]    count
);

   wb_entry_t        ent [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             push_ok;
   logic             pop_ok;

   assign full    = count == (PTR_W+1)'(DEPTH);
   assign push_ok = push && !full;
   assign pop_ok  = pop && (count != '0);

   assign hit_line  = ent[hit_idx].line[LINE_W-1:0];
   assign head_tag  = ent[head].tag[TAG_W-1:0];
   assign head_line = ent[head].line[LINE_W-1:0];

   // Parallel tag compare; at most one entry can match.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ent[i].valid && ent[i].tag[TAG_W-1:0] == lookup_tag) begin
            hit     = 1'b1;
            hit_idx = PTR_W'(i);
         end
      end
   end

   // Entry storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         if (ovw) ent[hit_idx].line <= MAX_LINE_W'(wr_line);
         if (push_ok) begin
            ent[tail].valid <= 1'b1;
            ent[tail].tag   <= MAX_TAG_W'(push_tag);
            ent[tail].line  <= MAX_LINE_W'(wr_line);
            tail            <= tail + 1'b1;
         end
         if (pop_ok) begin
            ent[head].valid <= 1'b0;
            head            <= head + 1'b1;
         end
         if (push_ok && !pop_ok) count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/l2_writeback_buffer.sv
// Victim buffer between L2 and the cacheline adaptor.
// Absorbs evictions, forwards hits, drains when idle.
module l2_writeback_buffer
   import wb_buffer_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int LINE_W = 256,
   parameter  int ADDR_W = 32,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              l2_read,
   input  logic              l2_write,
   input  logic [ADDR_W-1:0] l2_address,
   input  logic [LINE_W-1:0] l2_wdata,
   output logic [LINE_W-1:0] l2_rdata,
   output logic              l2_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic [CNT_W-1:0]  wb_count
);

   localparam int TAG_W = ADDR_W - LINE_OFFSET;
   localparam int PTR_W = $clog2(DEPTH);

   wb_state_e         state;
   wb_state_e         state_nxt;
   logic [TAG_W-1:0]  req_tag;
   logic [TAG_W-1:0]  head_tag;
   logic [LINE_W-1:0] hit_line;
   logic [LINE_W-1:0] head_line;
   logic [PTR_W-1:0]  hit_idx;
   logic [CNT_W-1:0]  count;
   logic              hit;
   logic              full;
   logic              push;
   logic              ovw;
   logic              pop;
   logic              wr_req;
   logic              unused_offset;

   assign req_tag       = l2_address[ADDR_W-1:LINE_OFFSET];
   assign unused_offset = ^l2_address[LINE_OFFSET-1:0];
   assign wb_count      = count;
   assign wr_req        = l2_write && !l2_read;

   wb_fifo #(
      .DEPTH  (DEPTH),
      .LINE_W (LINE_W),
      .TAG_W  (TAG_W)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .lookup_tag (req_tag),
      .hit        (hit),
      .hit_idx    (hit_idx),
      .hit_line   (hit_line),
      .push       (push),
      .ovw        (ovw),
      .pop        (pop),
      .push_tag   (req_tag),
      .wr_line    (l2_wdata),
      .head_tag   (head_tag),
      .head_line  (head_line),
      .full       (full),
      .count      (count)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state: reads win, buffer hits finish in one cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (l2_read)            state_nxt = hit ? RESP : MEM_READ;
            else if (l2_write)      state_nxt = (hit || !full) ? RESP : DRAIN;
            else if (count != '0)   state_nxt = DRAIN;
         end
         MEM_READ: if (mem_resp) state_nxt = RESP;
         DRAIN:    if (mem_resp) state_nxt = IDLE;
         RESP:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // State-decoded handshakes and FIFO controls.
   always_comb begin
      mem_read  = state == MEM_READ;
      mem_write = state == DRAIN;
      l2_resp   = state == RESP;
      ovw       = (state == IDLE) && wr_req && hit;
      push      = (state == IDLE) && wr_req && !hit && !full;
      pop       = (state == DRAIN) && mem_resp;
   end

   // Registered data outputs; addresses latched on request entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         l2_rdata    <= '0;
         mem_address <= '0;
         mem_wdata   <= '0;
      end else begin
         if (state == IDLE && l2_read && hit) l2_rdata <= hit_line;
         if (state == MEM_READ && mem_resp)   l2_rdata <= mem_rdata;
         if (state == IDLE && state_nxt == DRAIN) begin
            mem_address <= {head_tag, {LINE_OFFSET{1'b0}}};
            mem_wdata   <= head_line;
         end
         if (state == IDLE && state_nxt == MEM_READ)
            mem_address <= {req_tag, {LINE_OFFSET{1'b0}}};
      end
   end

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Bench for l2_writeback_buffer.
// Directed scenarios plus a random run against a line-level model.
module tb_l2_writeback_buffer;

   typedef logic [255:0] line_t;
   typedef struct {
      logic [31:0] a;
      line_t       d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        l2_read = 1'b0;
   logic        l2_write = 1'b0;
   logic [31:0] l2_address = '0;
   line_t       l2_wdata = '0;
   line_t       l2_rdata;
   logic        l2_resp;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   line_t       mem_wdata;
   line_t       mem_rdata = '0;
   logic        mem_resp = 1'b0;
   logic [2:0]  wb_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   wr_t   wlog[$];
   wr_t   mq[$];
   line_t mem_model[logic [31:0]];
   line_t latest[logic [31:0]];

   int lat = 1;
   bit stall = 1'b0;
   int rcnt = 0;
   int mresp_cyc = -1;
   int rd_cycles = 0;
   int first_rd_cyc = -1;
   logic [31:0] rd_addr_seen = '0;

   l2_writeback_buffer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .l2_read     (l2_read),
      .l2_write    (l2_write),
      .l2_address  (l2_address),
      .l2_wdata    (l2_wdata),
      .l2_rdata    (l2_rdata),
      .l2_resp     (l2_resp),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp),
      .wb_count    (wb_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] la(input logic [31:0] a);
      return {a[31:5], 5'b0};
   endfunction

   function automatic line_t bg(input logic [31:0] a);
      return {8{a ^ 32'hC0DE_0000}};
   endfunction

   function automatic line_t expect_line(input logic [31:0] a);
      if (latest.exists(la(a))) return latest[la(a)];
      return bg(la(a));
   endfunction

   function automatic line_t rand_line();
      line_t d;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   // Adaptor model: fixed latency, optional stall.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n) begin
            mem_resp = 1'b0;
            rcnt = 0;
         end else if (mem_resp) begin
            mem_resp = 1'b0;
         end else if ((mem_read || mem_write) && !stall) begin
            if (rcnt >= lat - 1) begin
               rcnt = 0;
               mem_resp = 1'b1;
               mresp_cyc = cyc;
               if (mem_write) begin
                  mem_model[mem_address] = mem_wdata;
                  wlog.push_back('{mem_address, mem_wdata});
               end else begin
                  mem_rdata = mem_model.exists(mem_address) ?
                              mem_model[mem_address] : bg(mem_address);
               end
            end else begin
               rcnt++;
            end
         end
      end
   end

   // Memory read activity monitor.
   always @(negedge clk) begin
      if (mem_read) begin
         rd_cycles = rd_cycles + 1;
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
         rd_addr_seen = mem_address;
      end
   end

   task automatic l2_op(input bit wr, input logic [31:0] a, input line_t d,
                        output line_t rd, output int st, output int rc,
                        output int cn, output bit to);
      st = cyc;
      to = 1'b1;
      rd = '0;
      rc = -1;
      cn = -1;
      l2_address = a;
      l2_wdata = d;
      l2_read = !wr;
      l2_write = wr;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (l2_resp) begin
            rd = l2_rdata;
            rc = cyc;
            cn = int'(wb_count);
            to = 1'b0;
            break;
         end
      end
      l2_read = 1'b0;
      l2_write = 1'b0;
   endtask

   task automatic settle(output bit to);
      to = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (!mem_read && !mem_write && !l2_resp && wb_count == 0) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (l2_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b%b%b expected 000",
                  l2_resp, mem_read, mem_write);
      end
      checks++;
      if (l2_rdata !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h/%h expected 0", l2_rdata, mem_wdata);
      end
      checks++;
      if (mem_address !== '0 || wb_count !== 3'd0) begin
         errors++;
         $display("FAIL reset_addr_count: got %h/%0d expected 0/0",
                  mem_address, wb_count);
      end
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || wb_count !== 3'd0) begin
         errors++;
         $display("FAIL post_reset_idle: got %b%b/%0d expected 00/0",
                  mem_read, mem_write, wb_count);
      end
   endtask

   task automatic test_write_drain();
      line_t rd, a_line;
      int st, rc, cn;
      bit to;
      a_line = rand_line();
      settle(to);
      wlog.delete();
      l2_op(1'b1, 32'h1000, a_line, rd, st, rc, cn, to);
      latest[32'h1000] = a_line;
      checks++;
      if (to || rc - st != 1) begin
         errors++;
         $display("FAIL wr_latency: got %0d expected 1", rc - st);
      end
      checks++;
      if (cn != 1) begin
         errors++;
         $display("FAIL wr_count: got %0d expected 1", cn);
      end
      settle(to);
      checks++;
      if (to || wlog.size() != 1) begin
         errors++;
         $display("FAIL drain_count: got %0d expected 1", wlog.size());
      end else begin
         checks++;
         if (wlog[0].a !== 32'h1000 || wlog[0].d !== a_line) begin
            errors++;
            $display("FAIL drain_data: got %h expected 1000", wlog[0].a);
         end
      end
      checks++;
      if (wb_count !== 3'd0) begin
         errors++;
         $display("FAIL drain_empty: got %0d expected 0", wb_count);
      end
   endtask

   task automatic test_read_forward();
      line_t rd, b_line;
      int st, rc, cn, wrc;
      bit to;
      b_line = rand_line();
      settle(to);
      l2_op(1'b1, 32'h2000, b_line, rd, st, wrc, cn, to);
      latest[32'h2000] = b_line;
      rd_cycles = 0;
      l2_op(1'b0, 32'h2004, '0, rd, st, rc, cn, to);
      checks++;
      if (to || rd !== b_line) begin
         errors++;
         $display("FAIL fwd_data: got %h expected %h", rd, b_line);
      end
      checks++;
      if (rc != wrc + 2) begin
         errors++;
         $display("FAIL fwd_latency: got %0d expected %0d", rc, wrc + 2);
      end
      checks++;
      if (rd_cycles != 0) begin
         errors++;
         $display("FAIL fwd_no_mem: got %0d expected 0", rd_cycles);
      end
   endtask

   task automatic test_coalesce();
      line_t rd, c_line, d_line;
      int st, rc, cn;
      bit to;
      c_line = rand_line();
      d_line = rand_line();
      settle(to);
      wlog.delete();
      l2_op(1'b1, 32'h3000, c_line, rd, st, rc, cn, to);
      l2_op(1'b1, 32'h3000, d_line, rd, st, rc, cn, to);
      latest[32'h3000] = d_line;
      checks++;
      if (to || cn != 1) begin
         errors++;
         $display("FAIL coal_count: got %0d expected 1", cn);
      end
      settle(to);
      checks++;
      if (wlog.size() != 1) begin
         errors++;
         $display("FAIL coal_writes: got %0d expected 1", wlog.size());
      end else begin
         checks++;
         if (wlog[0].a !== 32'h3000 || wlog[0].d !== d_line) begin
            errors++;
            $display("FAIL coal_data: got %h expected %h", wlog[0].d, d_line);
         end
      end
   endtask

   task automatic test_full();
      line_t rd, d;
      line_t lines[5];
      int st, rc, cn;
      bit to;
      settle(to);
      wlog.delete();
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         lines[i] = rand_line();
         l2_op(1'b1, 32'h6000 + 32'(i * 32), lines[i], rd, st, rc, cn, to);
         latest[32'h6000 + 32'(i * 32)] = lines[i];
      end
      checks++;
      if (to || cn != 4) begin
         errors++;
         $display("FAIL full_count: got %0d expected 4", cn);
      end
      fork
         begin
            repeat (8) @(posedge clk);
            stall = 1'b0;
         end
      join_none
      lines[4] = rand_line();
      d = lines[4];
      l2_op(1'b1, 32'h6080, d, rd, st, rc, cn, to);
      latest[32'h6080] = d;
      checks++;
      if (to || wlog.size() != 1 || wlog[0].a !== 32'h6000) begin
         errors++;
         $display("FAIL full_head_first: got %0d writes expected 1 to 6000",
                  wlog.size());
      end
      checks++;
      if (rc - mresp_cyc != 2) begin
         errors++;
         $display("FAIL full_latency: got %0d expected 2", rc - mresp_cyc);
      end
      checks++;
      if (cn != 4) begin
         errors++;
         $display("FAIL full_count_after: got %0d expected 4", cn);
      end
      settle(to);
      checks++;
      if (to || wlog.size() != 5) begin
         errors++;
         $display("FAIL full_drains: got %0d expected 5", wlog.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (wlog[i].a !== 32'h6000 + 32'(i * 32) || wlog[i].d !== lines[i]) begin
               errors++;
               $display("FAIL full_order: got %h expected %h",
                        wlog[i].a, 32'h6000 + 32'(i * 32));
            end
         end
      end
   endtask

   task automatic test_read_miss();
      line_t rd;
      int st, rc, cn;
      bit to;
      settle(to);
      lat = 10;
      rd_cycles = 0;
      first_rd_cyc = -1;
      l2_op(1'b0, 32'h4000, '0, rd, st, rc, cn, to);
      lat = 1;
      checks++;
      if (to || rd !== expect_line(32'h4000)) begin
         errors++;
         $display("FAIL miss_data: got %h expected %h", rd, expect_line(32'h4000));
      end
      checks++;
      if (rd_cycles != 10) begin
         errors++;
         $display("FAIL miss_hold: got %0d expected 10", rd_cycles);
      end
      checks++;
      if (first_rd_cyc != st + 1) begin
         errors++;
         $display("FAIL miss_start: got %0d expected %0d", first_rd_cyc, st + 1);
      end
      checks++;
      if (rc != mresp_cyc + 1) begin
         errors++;
         $display("FAIL miss_resp: got %0d expected %0d", rc, mresp_cyc + 1);
      end
      checks++;
      if (rd_addr_seen !== 32'h4000) begin
         errors++;
         $display("FAIL miss_addr: got %h expected 4000", rd_addr_seen);
      end
   endtask

   task automatic test_reset_mid_drain();
      line_t rd, e_line;
      int st, rc, cn;
      bit to, seen;
      e_line = rand_line();
      settle(to);
      stall = 1'b1;
      l2_op(1'b1, 32'h5000, e_line, rd, st, rc, cn, to);
      latest[32'h5000] = e_line;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (mem_write) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rst_drain_start: got 0 expected 1");
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0 || l2_resp !== 1'b0) begin
         errors++;
         $display("FAIL rst_async_strobes: got %b%b%b expected 000",
                  mem_write, mem_read, l2_resp);
      end
      checks++;
      if (mem_address !== '0 || mem_wdata !== '0 || l2_rdata !== '0) begin
         errors++;
         $display("FAIL rst_async_data: got %h expected 0", mem_address);
      end
      checks++;
      if (wb_count !== 3'd0) begin
         errors++;
         $display("FAIL rst_async_count: got %0d expected 0", wb_count);
      end
      latest = mem_model;
      wlog.delete();
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      stall = 1'b0;
      @(posedge clk);
      #1;
      rd_cycles = 0;
      l2_op(1'b0, 32'h5000, '0, rd, st, rc, cn, to);
      checks++;
      if (to || rd !== expect_line(32'h5000)) begin
         errors++;
         $display("FAIL rst_read_data: got %h expected %h",
                  rd, expect_line(32'h5000));
      end
      checks++;
      if (rd_cycles != lat) begin
         errors++;
         $display("FAIL rst_read_mem: got %0d expected %0d", rd_cycles, lat);
      end
   endtask

   task automatic test_random();
      line_t rd, d;
      logic [31:0] a;
      int st, rc, cn, idx;
      bit to, wr;
      wr_t w;
      settle(to);
      mq.delete();
      wlog.delete();
      for (int n = 0; n < 80; n++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         lat = $urandom_range(1, 3);
         wr = 1'($urandom_range(0, 1));
         a = 32'h8000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31));
         d = rand_line();
         l2_op(wr, a, d, rd, st, rc, cn, to);
         checks++;
         if (to) begin
            errors++;
            $display("FAIL rnd_timeout: got none expected l2_resp op %0d", n);
         end
         while (wlog.size() > 0) begin
            w = wlog.pop_front();
            checks++;
            if (mq.size() == 0 || mq[0].a !== w.a || mq[0].d !== w.d) begin
               errors++;
               $display("FAIL rnd_drain: got %h expected oldest buffered line", w.a);
            end
            if (mq.size() > 0) void'(mq.pop_front());
         end
         if (wr) begin
            idx = -1;
            foreach (mq[i]) if (mq[i].a == la(a)) idx = i;
            if (idx >= 0) mq[idx].d = d;
            else mq.push_back('{la(a), d});
            latest[la(a)] = d;
         end else begin
            checks++;
            if (rd !== expect_line(a)) begin
               errors++;
               $display("FAIL rnd_read: got %h expected %h", rd, expect_line(a));
            end
         end
         checks++;
         if (cn != mq.size()) begin
            errors++;
            $display("FAIL rnd_count: got %0d expected %0d", cn, mq.size());
         end
      end
      settle(to);
      while (wlog.size() > 0) begin
         w = wlog.pop_front();
         checks++;
         if (mq.size() == 0 || mq[0].a !== w.a || mq[0].d !== w.d) begin
            errors++;
            $display("FAIL rnd_final_drain: got %h expected oldest line", w.a);
         end
         if (mq.size() > 0) void'(mq.pop_front());
      end
      checks++;
      if (to || mq.size() != 0) begin
         errors++;
         $display("FAIL rnd_leftover: got %0d expected 0", mq.size());
      end
      lat = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_drain();
      test_read_forward();
      test_coalesce();
      test_full();
      test_read_miss();
      test_reset_mid_drain();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
